regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised successor of the processor register file: NUM_REGS x DATA_WIDTH, one write
//  port, two async read ports. Adds write-to-read bypass, per-register busy scoreboard for
//  pipeline stall logic, and a sequential soft-clear engine (one register per cycle).
//  Sits between decode (reads, busy set) and writeback (writes) in the pipeline.
// PARAMETERS
//  DATA_WIDTH  32  bits per register
//  ADDR_WIDTH  5   register address width
//  NUM_REGS    32  registers implemented, <= 2**ADDR_WIDTH, >= 2
//  ZERO_REG    1   1: register 0 reads 0, ignores writes, never busy
//  BYPASS      1   1: same-cycle write data forwarded to matching read port
// PORTS
//  clock             in   1           rising-edge clock, only clock
//  ctrl_reset_n      in   1           synchronous active-low reset
//  ctrl_writeEnable  in   1           commit data_writeReg to ctrl_writeReg
//  ctrl_writeReg     in   ADDR_WIDTH  write address
//  data_writeReg     in   DATA_WIDTH  write data
//  ctrl_readRegA     in   ADDR_WIDTH  read address A
//  ctrl_readRegB     in   ADDR_WIDTH  read address B
//  data_readRegA     out  DATA_WIDTH  read data A (combinational)
//  data_readRegB     out  DATA_WIDTH  read data B (combinational)
//  ctrl_setBusy      in   1           mark ctrl_busyReg pending (instruction issue)
//  ctrl_busyReg      in   ADDR_WIDTH  register to mark busy
//  busy_readRegA     out  1           busy bit of ctrl_readRegA (combinational)
//  busy_readRegB     out  1           busy bit of ctrl_readRegB (combinational)
//  ctrl_clear        in   1           pulse: start soft-clear sweep
//  clear_active      out  1           sweep in progress; writes/setBusy dropped
// BEHAVIOUR
//  Reset (ctrl_reset_n=0 at clock edge): all registers 0, all busy bits 0, FSM IDLE,
//   clear_active 0; dominates every other input that cycle, including mid-sweep.
//  Reads: async; address >= NUM_REGS reads 0, busy 0. ZERO_REG: address 0 reads 0, busy 0.
//  Write: at edge when ctrl_writeEnable & ~clear_active & addr valid (and nonzero if ZERO_REG);
//   visible on reads the following cycle; clears that register's busy bit.
//  Bypass (BYPASS=1): read addr == qualified write addr in same cycle -> read port returns
//   data_writeReg and busy_read* returns 0 that cycle. BYPASS=0: old value until edge.
//  Busy set: at edge when ctrl_setBusy & ~clear_active & addr valid (nonzero if ZERO_REG).
//   Set and write-clear to same register same edge -> busy ends 1 (set wins).
//  Writes to out-of-range or zero address are silently dropped.
//  FSM IDLE: ctrl_clear=1 -> SWEEP, ptr<=0, clear_active<=1 from next cycle.
//  FSM SWEEP: each edge reg[ptr]<=0, busy[ptr]<=0, ptr<=ptr+1; at ptr==NUM_REGS-1 -> IDLE.
//   Sweep lasts exactly NUM_REGS cycles; clear_active high for those cycles only.
//   ctrl_clear during SWEEP ignored (no restart). Write coinciding with the ctrl_clear
//   cycle in IDLE still commits (before sweep reaches it, then gets zeroed).
//  Reads during SWEEP return current contents (uncleared regs keep old data); bypass off.
//  ptr width = ADDR_WIDTH; no wrap beyond NUM_REGS-1.
// TESTING
//  1 Reset, write r5=0xDEADBEEF, next cycle read A=5,B=5 -> both 0xDEADBEEF; r0 write 0x1 -> reads 0.
//  2 Same cycle write r7=0x1234, readA=7: BYPASS=1 -> 0x1234 that cycle; BYPASS=0 -> 0 then 0x1234.
//  3 setBusy r3 -> busy_readRegA(3)=1; write r3 -> busy 0 next cycle; set+write r3 same edge -> busy 1.
//  4 Fill r1..r31 with i, pulse ctrl_clear -> clear_active high 32 cycles, all read 0 after, busy 0.
//  5 Write/setBusy during sweep -> dropped; ctrl_clear mid-sweep -> sweep ends at original 32 cycles.
//  6 ctrl_reset_n=0 mid-sweep at cycle 10 -> IDLE, clear_active 0, all regs 0 next cycle.

Source files
------------

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//
// Parametrised processor register file: NUM_REGS x DATA_WIDTH storage with one
// synchronous write port and two asynchronous read ports. On top of the plain
// storage it provides:
//   - write-to-read bypass, so a reader sees data being written this cycle;
//   - a per-register busy scoreboard that decode sets at issue and writeback
//     clears on commit, used by the pipeline to detect RAW hazards;
//   - a soft-clear engine that walks the file zeroing one register (and its
//     busy bit) per cycle, without needing a full reset.
//
// Parameters
//   DATA_WIDTH  bits per register
//   ADDR_WIDTH  register address width
//   NUM_REGS    registers implemented (2 .. 2**ADDR_WIDTH)
//   ZERO_REG    1: register 0 reads 0, ignores writes, never busy
//   BYPASS      1: same-cycle write data forwarded to a matching read port
//
// Ports
//   clock             rising-edge clock
//   ctrl_reset_n      synchronous active-low reset, overrides everything
//   ctrl_writeEnable  commit data_writeReg into ctrl_writeReg
//   ctrl_writeReg     write address
//   data_writeReg     write data
//   ctrl_readRegA/B   read addresses
//   data_readRegA/B   read data (combinational)
//   ctrl_setBusy      mark ctrl_busyReg as having a pending result
//   ctrl_busyReg      register to mark busy
//   busy_readRegA/B   busy bit of the register being read (combinational)
//   ctrl_clear        pulse to start a soft-clear sweep
//   clear_active      sweep in progress; writes and busy sets are dropped
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_setBusy,
    input  logic [ADDR_WIDTH-1:0] ctrl_busyReg,
    output logic                  busy_readRegA,
    output logic                  busy_readRegB,
    input  logic                  ctrl_clear,
    output logic                  clear_active
);

    // One extra bit so NUM_REGS == 2**ADDR_WIDTH still fits in the compare.
    localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   ptr_next;
    logic                    sweep_en;

    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0]     busy;

    logic                    write_ok;
    logic                    set_ok;
    logic                    read_a_ok;
    logic                    read_b_ok;
    logic                    fwd_a;
    logic                    fwd_b;
    logic [DATA_WIDTH-1:0]   raw_a;
    logic [DATA_WIDTH-1:0]   raw_b;
    logic                    raw_busy_a;
    logic                    raw_busy_b;

    // An address names real storage when it is below NUM_REGS and, with the
    // hardwired zero register, is not register 0.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
        logic ok;
        ok = ({1'b0, addr} < NUM_REGS_W);
        if ((ZERO_REG != 0) && (addr == '0)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    assign clear_active = (state == SWEEP);

    // Qualified write and busy-set strobes. Both are suppressed while the
    // sweep owns the file, so the sweep never races a normal update.
    assign write_ok  = ctrl_writeEnable & ~clear_active & addr_ok(ctrl_writeReg);
    assign set_ok    = ctrl_setBusy     & ~clear_active & addr_ok(ctrl_busyReg);
    assign read_a_ok = addr_ok(ctrl_readRegA);
    assign read_b_ok = addr_ok(ctrl_readRegB);

    // Forwarding only triggers on a write that will actually commit, which
    // also keeps bypass off during a sweep.
    assign fwd_a = (BYPASS != 0) && write_ok && (ctrl_writeReg == ctrl_readRegA);
    assign fwd_b = (BYPASS != 0) && write_ok && (ctrl_writeReg == ctrl_readRegB);

    // FSM state and sweep pointer register.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Next-state logic. A clear request only starts a sweep from IDLE; a
    // second request mid-sweep is ignored so the sweep length stays fixed.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        sweep_en   = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_clear) begin
                    state_next = SWEEP;
                    ptr_next   = '0;
                end
            end
            SWEEP: begin
                sweep_en = 1'b1;
                if (ptr == LAST_PTR) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // Register storage. The sweep zeroes the entry under the pointer; at any
    // other time the qualified write port updates its target.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sweep_en && (ptr == ADDR_WIDTH'(i))) begin
                    regs[i] <= '0;
                end else if (write_ok && (ctrl_writeReg == ADDR_WIDTH'(i))) begin
                    regs[i] <= data_writeReg;
                end
            end
        end
    end

    // Busy scoreboard. A commit clears the bit, but an issue to the same
    // register in the same cycle belongs to a newer instruction, so the set
    // is applied last and wins.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sweep_en && (ptr == ADDR_WIDTH'(i))) begin
                    busy[i] <= 1'b0;
                end else if (set_ok && (ctrl_busyReg == ADDR_WIDTH'(i))) begin
                    busy[i] <= 1'b1;
                end else if (write_ok && (ctrl_writeReg == ADDR_WIDTH'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Asynchronous read muxes over the stored contents. Addresses with no
    // matching entry fall through to the zero default.
    always_comb begin
        raw_a      = '0;
        raw_b      = '0;
        raw_busy_a = 1'b0;
        raw_busy_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ctrl_readRegA == ADDR_WIDTH'(i)) begin
                raw_a      = regs[i];
                raw_busy_a = busy[i];
            end
            if (ctrl_readRegB == ADDR_WIDTH'(i)) begin
                raw_b      = regs[i];
                raw_busy_b = busy[i];
            end
        end
    end

    // Final read outputs: invalid addresses read as zero and never busy; a
    // forwarded value is by definition the completed result, so not busy.
    always_comb begin
        data_readRegA = '0;
        data_readRegB = '0;
        busy_readRegA = 1'b0;
        busy_readRegB = 1'b0;
        if (read_a_ok) begin
            data_readRegA = fwd_a ? data_writeReg : raw_a;
            busy_readRegA = fwd_a ? 1'b0 : raw_busy_a;
        end
        if (read_b_ok) begin
            data_readRegB = fwd_b ? data_writeReg : raw_b;
            busy_readRegB = fwd_b ? 1'b0 : raw_busy_b;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//
// Self-checking bench for regfile_param with default parameters. Keeps a
// behavioural model of the register file (contents, busy flags, and the
// number of sweep cycles remaining) and compares every read port, busy port
// and clear_active once per cycle, plus a few fixed-value spot checks.
// ---------------------------------------------------------------------------
module tb_regfile_param;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clock = 1'b0;
    logic          ctrl_reset_n;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic [AW-1:0] ctrl_readRegA;
    logic [AW-1:0] ctrl_readRegB;
    logic [DW-1:0] data_readRegA;
    logic [DW-1:0] data_readRegB;
    logic          ctrl_setBusy;
    logic [AW-1:0] ctrl_busyReg;
    logic          busy_readRegA;
    logic          busy_readRegB;
    logic          ctrl_clear;
    logic          clear_active;

    int checkCount = 0;
    int failCount  = 0;

    logic [DW-1:0] modelRegs [NR];
    logic          modelBusy [NR];
    int            sweepLeft;

    always #5 clock = ~clock;

    regfile_param #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REGS  (NR),
        .ZERO_REG  (1),
        .BYPASS    (1)
    ) dut (
        .clock           (clock),
        .ctrl_reset_n    (ctrl_reset_n),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg   (ctrl_writeReg),
        .data_writeReg   (data_writeReg),
        .ctrl_readRegA   (ctrl_readRegA),
        .ctrl_readRegB   (ctrl_readRegB),
        .data_readRegA   (data_readRegA),
        .data_readRegB   (data_readRegB),
        .ctrl_setBusy    (ctrl_setBusy),
        .ctrl_busyReg    (ctrl_busyReg),
        .busy_readRegA   (busy_readRegA),
        .busy_readRegB   (busy_readRegB),
        .ctrl_clear      (ctrl_clear),
        .clear_active    (clear_active)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // A register address that refers to real, writable storage.
    function automatic bit realReg(input logic [AW-1:0] a);
        return (a != 0) && (int'(a) < NR);
    endfunction

    function automatic logic [DW-1:0] expData(input logic [AW-1:0] a);
        if (!realReg(a)) return '0;
        if (sweepLeft == 0 && ctrl_writeEnable && ctrl_writeReg == a) return data_writeReg;
        return modelRegs[a];
    endfunction

    function automatic logic [DW-1:0] expBusy(input logic [AW-1:0] a);
        if (!realReg(a)) return '0;
        if (sweepLeft == 0 && ctrl_writeEnable && ctrl_writeReg == a) return '0;
        return {{(DW-1){1'b0}}, modelBusy[a]};
    endfunction

    // Advance the model across one rising edge using the inputs held then.
    task automatic updateModel();
        if (!ctrl_reset_n) begin
            for (int i = 0; i < NR; i++) begin
                modelRegs[i] = '0;
                modelBusy[i] = 1'b0;
            end
            sweepLeft = 0;
        end else if (sweepLeft > 0) begin
            modelRegs[NR - sweepLeft] = '0;
            modelBusy[NR - sweepLeft] = 1'b0;
            sweepLeft--;
        end else begin
            if (ctrl_writeEnable && realReg(ctrl_writeReg)) begin
                modelRegs[ctrl_writeReg] = data_writeReg;
                modelBusy[ctrl_writeReg] = 1'b0;
            end
            if (ctrl_setBusy && realReg(ctrl_busyReg)) begin
                modelBusy[ctrl_busyReg] = 1'b1;
            end
            if (ctrl_clear) begin
                sweepLeft = NR;
            end
        end
    endtask

    // Drive one cycle of inputs, check all outputs mid-cycle, then clock.
    task automatic applyStimulus(input logic rstN, input logic we, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                                 input logic [AW-1:0] rb, input logic sb,
                                 input logic [AW-1:0] br, input logic clr);
        ctrl_reset_n     = rstN;
        ctrl_writeEnable = we;
        ctrl_writeReg    = wa;
        data_writeReg    = wd;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        ctrl_setBusy     = sb;
        ctrl_busyReg     = br;
        ctrl_clear       = clr;
        #3;
        checkOutput("readA", data_readRegA, expData(ra));
        checkOutput("readB", data_readRegB, expData(rb));
        checkOutput("busyA", {{(DW-1){1'b0}}, busy_readRegA}, expBusy(ra));
        checkOutput("busyB", {{(DW-1){1'b0}}, busy_readRegB}, expBusy(rb));
        checkOutput("clearActive", {{(DW-1){1'b0}}, clear_active}, (sweepLeft != 0) ? 1 : 0);
        @(posedge clock);
        updateModel();
        #1;
    endtask

    task automatic idleCycle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        applyStimulus(1'b1, 1'b0, '0, '0, ra, rb, 1'b0, '0, 1'b0);
    endtask

    // Point the read ports somewhere without clocking, for fixed-value checks.
    task automatic probe(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        ctrl_writeEnable = 1'b0;
        ctrl_setBusy     = 1'b0;
        ctrl_clear       = 1'b0;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        #2;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            modelRegs[i] = 'x;
            modelBusy[i] = 1'bx;
        end
        sweepLeft = 0;
        ctrl_reset_n = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg = '0;
        data_writeReg = '0;
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        ctrl_setBusy = 1'b0;
        ctrl_busyReg = '0;
        ctrl_clear = 1'b0;
        @(posedge clock);
        updateModel();
        #1;
        applyStimulus(1'b0, 1'b0, '0, '0, 5'd5, 5'd9, 1'b0, '0, 1'b0);
        $display("[TB] reset applied");

        // Basic write then read, and the hardwired zero register.
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0, '0, 1'b0);
        idleCycle(5'd5, 5'd5);
        probe(5'd5, 5'd5);
        checkOutput("t1_r5A", data_readRegA, 32'hDEADBEEF);
        checkOutput("t1_r5B", data_readRegB, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h1, 5'd0, 5'd0, 1'b0, '0, 1'b0);
        probe(5'd0, 5'd5);
        checkOutput("t1_r0", data_readRegA, 32'h0);

        // Same-cycle bypass.
        ctrl_reset_n = 1'b1;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg = 5'd7;
        data_writeReg = 32'h1234;
        ctrl_readRegA = 5'd7;
        #1;
        checkOutput("t2_bypass", data_readRegA, 32'h1234);
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h1234, 5'd7, 5'd6, 1'b0, '0, 1'b0);
        idleCycle(5'd7, 5'd7);

        // Busy scoreboard: set, clear by write, set wins over write.
        applyStimulus(1'b1, 1'b0, '0, '0, 5'd3, 5'd3, 1'b1, 5'd3, 1'b0);
        probe(5'd3, 5'd0);
        checkOutput("t3_busySet", {31'b0, busy_readRegA}, 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'hA5, 5'd3, 5'd4, 1'b0, '0, 1'b0);
        probe(5'd3, 5'd0);
        checkOutput("t3_busyCleared", {31'b0, busy_readRegA}, 32'd0);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h5A, 5'd4, 5'd5, 1'b1, 5'd3, 1'b0);
        probe(5'd3, 5'd0);
        checkOutput("t3_setWins", {31'b0, busy_readRegA}, 32'd1);

        // Fill, then sweep; a write and a busy set ride along with the clear
        // pulse and must still commit before being swept.
        for (int i = 1; i < NR; i++) begin
            applyStimulus(1'b1, 1'b1, AW'(i), DW'(i), AW'(i), AW'(i - 1), 1'b0, '0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 5'd31, 32'hCAFE, 5'd2, 5'd3, 1'b1, 5'd9, 1'b1);
        for (int c = 0; c < NR; c++) begin
            // Writes, busy sets and repeat clears all land mid-sweep.
            applyStimulus(1'b1, 1'b1, AW'($urandom_range(31)), $urandom,
                          AW'($urandom_range(31)), AW'(NR - 1 - c), 1'b1,
                          AW'($urandom_range(31)), (c == 5) ? 1'b1 : 1'b0);
        end
        probe(5'd31, 5'd9);
        checkOutput("t4_r31Zero", data_readRegA, 32'h0);
        checkOutput("t4_busy9Zero", {31'b0, busy_readRegB}, 32'd0);
        checkOutput("t4_sweepDone", {31'b0, clear_active}, 32'd0);
        for (int i = 0; i < NR; i += 2) begin
            idleCycle(AW'(i), AW'(i + 1));
        end

        // Reset in the middle of a sweep.
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, AW'(i), $urandom, '0, '0, 1'b1, AW'(i + 8), 1'b0);
        end
        applyStimulus(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            idleCycle(AW'($urandom_range(31)), AW'($urandom_range(31)));
        end
        applyStimulus(1'b0, 1'b1, 5'd4, 32'hFFFF, 5'd4, 5'd12, 1'b1, 5'd4, 1'b0);
        probe(5'd7, 5'd12);
        checkOutput("t6_idle", {31'b0, clear_active}, 32'd0);
        checkOutput("t6_zero", data_readRegA, 32'h0);
        checkOutput("t6_notBusy", {31'b0, busy_readRegB}, 32'd0);

        // Random traffic with occasional clears and resets.
        for (int c = 0; c < 800; c++) begin
            applyStimulus(($urandom_range(199) != 0),
                          $urandom_range(1),
                          AW'($urandom_range(31)),
                          $urandom,
                          AW'($urandom_range(31)),
                          AW'($urandom_range(31)),
                          ($urandom_range(2) == 0),
                          AW'($urandom_range(31)),
                          ($urandom_range(59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
